// File: rtl/iobuf_ctrl_pkg.sv
// Shared types and helpers for the IOBUF vector sequencing controller.
package iobuf_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    DRIVE,
    CAPTURE,
    RESP
  } iobuf_ctrl_state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } iobuf_dir_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/iobuf_ctrl_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers who was served last.
module iobuf_ctrl_arb2 (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_one;  // 1 when requester 1 was served most recently

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_one ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_one <= 1'b1;
    end else if (advance) begin
      last_one <= grant[1];
    end
  end

endmodule

// File: rtl/iobuf_vec_ctrl.sv
// Arbitrates read/write commands from two requesters onto one tristate pin vector,
// inserting released-bus turnaround cycles whenever the bus direction changes.
module iobuf_vec_ctrl
  import iobuf_ctrl_pkg::*;
#(
  parameter int IOVEC_WIDTH   = 8,
  parameter int TURNAROUND    = 1,
  parameter int HOLD_CYCLES   = 1,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [1:0]             cmd_valid,
  output logic [1:0]             cmd_ready,
  input  logic [1:0]             cmd_write,
  input  logic [IOVEC_WIDTH-1:0] cmd_data0,
  input  logic [IOVEC_WIDTH-1:0] cmd_data1,
  output logic [1:0]             rsp_valid,
  output logic [IOVEC_WIDTH-1:0] rsp_data,
  output logic [IOVEC_WIDTH-1:0] pins_I,
  output logic                   pins_T,
  input  logic [IOVEC_WIDTH-1:0] pins_O
);

  localparam int CNT_MAX = max3(TURNAROUND, HOLD_CYCLES, SAMPLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  iobuf_ctrl_state_t      state, state_next;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             grant;
  logic                   hs;
  logic                   sel;
  iobuf_dir_t             sel_dir;
  logic [IOVEC_WIDTH-1:0] sel_data;
  logic                   id_q;
  iobuf_dir_t             dir_q;
  iobuf_dir_t             last_dir;
  logic [IOVEC_WIDTH-1:0] data_q;
  logic [IOVEC_WIDTH-1:0] rd_q;
  logic                   capture_last;

  iobuf_ctrl_arb2 u_arb (
    .CLK     (CLK),
    .nRST    (nRST),
    .valid   (cmd_valid),
    .advance (hs),
    .grant   (grant)
  );

  assign cmd_ready    = (state == IDLE) ? grant : 2'b00;
  assign hs           = |(cmd_valid & cmd_ready);
  assign sel          = grant[1];
  assign sel_dir      = iobuf_dir_t'(cmd_write[sel]);
  assign sel_data     = sel ? cmd_data1 : cmd_data0;
  assign capture_last = (state == CAPTURE) && (cnt == SAMPLE_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (hs) begin
          if (sel_dir != last_dir) state_next = TURN;
          else                     state_next = (sel_dir == WR) ? DRIVE : CAPTURE;
        end
      end
      TURN:    if (cnt == TURN_LAST) state_next = (dir_q == WR) ? DRIVE : CAPTURE;
      DRIVE:   if (cnt == HOLD_LAST) state_next = RESP;
      CAPTURE: if (cnt == SAMPLE_LAST) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      id_q     <= 1'b0;
      dir_q    <= RD;
      last_dir <= RD;
      data_q   <= '0;
      rd_q     <= '0;
      pins_I   <= '0;
    end else begin
      state <= state_next;
      // Each timed state exits on its last count, so the counter restarts instead of wrapping.
      if (state_next != state || state == IDLE) cnt <= '0;
      else                                      cnt <= cnt + CNT_W'(1);
      if (hs) begin
        id_q   <= sel;
        dir_q  <= sel_dir;
        data_q <= sel_data;
      end
      // Load the pad data on DRIVE entry; coming straight from IDLE the latch is not yet valid.
      if (state_next == DRIVE && state != DRIVE) pins_I <= (state == IDLE) ? sel_data : data_q;
      if (state == DRIVE)   last_dir <= WR;
      if (state == CAPTURE) last_dir <= RD;
      if (capture_last)     rd_q <= pins_O;
    end
  end

  assign pins_T    = (state != DRIVE);
  assign rsp_valid = (state == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = (state == RESP && dir_q == RD) ? rd_q : '0;

endmodule

// File: tb/tb_iobuf_vec_ctrl.sv
// Scoreboard bench for iobuf_vec_ctrl: default-parameter instance plus a
// TURNAROUND=3/HOLD=2/SAMPLE=1 instance for latency checks.
module tb_iobuf_vec_ctrl;

  localparam int W = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         nRST;
  logic [1:0]   cmd_valid, cmd_ready, cmd_write, rsp_valid;
  logic [W-1:0] cmd_data0, cmd_data1, rsp_data, pins_I, pins_O;
  logic         pins_T;

  logic [1:0]   b_cmd_valid, b_cmd_ready, b_cmd_write, b_rsp_valid;
  logic [W-1:0] b_cmd_data0, b_cmd_data1, b_rsp_data, b_pins_I, b_pins_O;
  logic         b_pins_T;

  iobuf_vec_ctrl #(.IOVEC_WIDTH(W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_data0 (cmd_data0),
    .cmd_data1 (cmd_data1),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .pins_I    (pins_I),
    .pins_T    (pins_T),
    .pins_O    (pins_O)
  );

  iobuf_vec_ctrl #(
    .IOVEC_WIDTH   (W),
    .TURNAROUND    (3),
    .HOLD_CYCLES   (2),
    .SAMPLE_CYCLES (1)
  ) dut_b (
    .CLK       (CLK),
    .nRST      (nRST),
    .cmd_valid (b_cmd_valid),
    .cmd_ready (b_cmd_ready),
    .cmd_write (b_cmd_write),
    .cmd_data0 (b_cmd_data0),
    .cmd_data1 (b_cmd_data1),
    .rsp_valid (b_rsp_valid),
    .rsp_data  (b_rsp_data),
    .pins_I    (b_pins_I),
    .pins_T    (b_pins_T),
    .pins_O    (b_pins_O)
  );

  typedef struct packed {
    logic [1:0]   vec;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Every response of the default instance must match the oldest expectation.
  always @(negedge CLK) begin
    if (nRST && rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_rsp_valid", {30'd0, rsp_valid}, {30'd0, mon_exp.vec});
        check("sb_rsp_data", {24'd0, rsp_data}, {24'd0, mon_exp.data});
      end
    end
  end

  // Present a command, wait (bounded) for ready, record the expected response, pass the handshake edge.
  task automatic issue(input int id, input bit wr, input logic [W-1:0] d, input logic [W-1:0] rsp);
    int n;
    n = 0;
    cmd_write[id] = wr;
    if (id == 0) cmd_data0 = d;
    else         cmd_data1 = d;
    cmd_valid[id] = 1'b1;
    #1;
    while (!cmd_ready[id] && n < 50) begin
      tick();
      n++;
    end
    check("issue_ready_timeout", {31'd0, n < 50}, 32'd1);
    sb.push_back('{vec: (id == 0) ? 2'b01 : 2'b10, data: rsp});
    tick();
    cmd_valid[id] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nRST        = 1'b0;
    cmd_valid   = 2'b00;
    cmd_write   = 2'b00;
    cmd_data0   = '0;
    cmd_data1   = '0;
    pins_O      = '0;
    b_cmd_valid = 2'b00;
    b_cmd_write = 2'b00;
    b_cmd_data0 = '0;
    b_cmd_data1 = '0;
    b_pins_O    = '0;
    #12;
    check("rst_pins_T", {31'd0, pins_T}, 32'd1);
    check("rst_pins_I", {24'd0, pins_I}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Both valid after reset: requester 0 has priority.
    cmd_write = 2'b11;
    cmd_valid = 2'b11;
    #1;
    check("rr_reset_prio", {30'd0, cmd_ready}, 32'h1);
    cmd_valid = 2'b00;
    #1;

    // First write after reset: TURN, DRIVE, RESP.
    issue(0, 1'b1, 8'hA5, 8'h00);
    check("w1_turn_T", {31'd0, pins_T}, 32'd1);
    tick();
    check("w1_drive_T", {31'd0, pins_T}, 32'd0);
    check("w1_drive_I", {24'd0, pins_I}, 32'hA5);
    tick();
    check("w1_resp_T", {31'd0, pins_T}, 32'd1);
    check("w1_resp_valid", {30'd0, rsp_valid}, 32'h1);
    check("w1_resp_data", {24'd0, rsp_data}, 32'h0);
    tick();

    // Second write, same direction: straight to DRIVE.
    issue(0, 1'b1, 8'h3C, 8'h00);
    check("w2_drive_T", {31'd0, pins_T}, 32'd0);
    check("w2_drive_I", {24'd0, pins_I}, 32'h3C);
    tick();
    check("w2_resp_T", {31'd0, pins_T}, 32'd1);
    check("w2_resp_valid", {30'd0, rsp_valid}, 32'h1);
    tick();

    // Read after write from requester 1: only the last CAPTURE cycle's pins_O counts.
    issue(1, 1'b0, 8'h00, 8'h5A);
    check("rd_turn_T", {31'd0, pins_T}, 32'd1);
    pins_O = 8'h11;
    tick();
    check("rd_cap1_T", {31'd0, pins_T}, 32'd1);
    pins_O = 8'h77;
    tick();
    check("rd_cap2_T", {31'd0, pins_T}, 32'd1);
    check("rd_cap2_no_rsp", {30'd0, rsp_valid}, 32'd0);
    pins_O = 8'h5A;
    tick();
    pins_O = 8'hFF;
    check("rd_resp_valid", {30'd0, rsp_valid}, 32'h2);
    check("rd_resp_data", {24'd0, rsp_data}, 32'h5A);
    check("rd_hold_I", {24'd0, pins_I}, 32'h3C);
    tick();

    // Both requesters valid continuously: grants alternate 0,1,0,1.
    cmd_write = 2'b11;
    cmd_data0 = 8'h01;
    cmd_data1 = 8'h02;
    cmd_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] eg;
      int m;
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      m  = 0;
      while (cmd_ready == 2'b00 && m < 50) begin
        tick();
        m++;
      end
      check("rr_ready_timeout", {31'd0, m < 50}, 32'd1);
      check("rr_grant", {30'd0, cmd_ready}, {30'd0, eg});
      sb.push_back('{vec: eg, data: 8'h00});
      tick();
      m = 0;
      while (pins_T && m < 10) begin
        tick();
        m++;
      end
      check("rr_drive_I", {24'd0, pins_I}, eg[1] ? 32'h2 : 32'h1);
    end
    cmd_valid = 2'b00;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check("rr_sb_drained", {31'd0, sb.size() == 0}, 32'd1);
    tick();

    // Reset in the middle of DRIVE drops the command.
    cmd_write[0] = 1'b1;
    cmd_data0    = 8'h99;
    cmd_valid    = 2'b01;
    #1;
    check("rst_mid_ready", {30'd0, cmd_ready}, 32'h1);
    tick();
    cmd_valid = 2'b00;
    check("rst_mid_drive_T", {31'd0, pins_T}, 32'd0);
    #2;
    nRST = 1'b0;
    #1;
    check("rst_mid_async_T", {31'd0, pins_T}, 32'd1);
    check("rst_mid_async_I", {24'd0, pins_I}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_mid_no_rsp", {30'd0, rsp_valid}, 32'd0);
    end

    // First write after that reset incurs TURN again.
    issue(0, 1'b1, 8'h42, 8'h00);
    check("w3_turn_T", {31'd0, pins_T}, 32'd1);
    tick();
    check("w3_drive_T", {31'd0, pins_T}, 32'd0);
    check("w3_drive_I", {24'd0, pins_I}, 32'h42);
    tick();
    tick();

    // TURNAROUND=3, HOLD=2, SAMPLE=1 instance: write after reset, then read after write.
    b_cmd_write = 2'b01;
    b_cmd_data0 = 8'h0F;
    b_cmd_valid = 2'b01;
    #1;
    check("b_wr_ready", {30'd0, b_cmd_ready}, 32'h1);
    tick();
    b_cmd_valid = 2'b00;
    n = 1;
    while (b_rsp_valid == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check("b_wr_latency", n, 32'd6);
    check("b_wr_rsp_data", {24'd0, b_rsp_data}, 32'h0);
    tick();

    b_cmd_write = 2'b00;
    b_pins_O    = 8'hC3;
    b_cmd_valid = 2'b01;
    #1;
    check("b_rd_ready", {30'd0, b_cmd_ready}, 32'h1);
    tick();
    b_cmd_valid = 2'b00;
    check("b_rd_turn_T", {31'd0, b_pins_T}, 32'd1);
    n = 1;
    while (b_rsp_valid == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check("b_rd_latency", n, 32'd5);
    check("b_rd_rsp_valid", {30'd0, b_rsp_valid}, 32'h1);
    check("b_rd_rsp_data", {24'd0, b_rsp_data}, 32'hC3);
    tick();

    check("sb_empty_at_end", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
